// File: rtl/pipe_skid_stage_pkg.sv
// ============================================================================
// Module   : pipe_skid_stage_pkg
// Brief    : State encoding, per-stage payload layout and NOP payloads for
//            the generic pipeline stage register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_e;

  localparam int PC_WIDTH       = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int RADDR_WIDTH    = 5;
  localparam int ALUOP_WIDTH    = 4;
  localparam int MEM_MODE_WIDTH = 3;

  // IF/ID payload: {pc, instr}
  localparam int c_ifid_instr_lsb = 0;
  localparam int c_ifid_pc_lsb    = c_ifid_instr_lsb + DATA_WIDTH;
  localparam int c_ifid_w         = c_ifid_pc_lsb + PC_WIDTH;

  // ID/EX payload: {pc, imm, rs2_val, rs1_val, rd, mem_mode, alu_op, ctrl[3:0]}
  // ctrl = {branch_jump, mem_read, mem_write, reg_write}
  localparam int c_idex_ctrl_lsb  = 0;
  localparam int c_idex_aluop_lsb = c_idex_ctrl_lsb + 4;
  localparam int c_idex_mmode_lsb = c_idex_aluop_lsb + ALUOP_WIDTH;
  localparam int c_idex_rd_lsb    = c_idex_mmode_lsb + MEM_MODE_WIDTH;
  localparam int c_idex_rs1_lsb   = c_idex_rd_lsb + RADDR_WIDTH;
  localparam int c_idex_rs2_lsb   = c_idex_rs1_lsb + DATA_WIDTH;
  localparam int c_idex_imm_lsb   = c_idex_rs2_lsb + DATA_WIDTH;
  localparam int c_idex_pc_lsb    = c_idex_imm_lsb + DATA_WIDTH;
  localparam int c_idex_w         = c_idex_pc_lsb + PC_WIDTH;

  // EX/MEM payload: {alu_res, store_val, rd, mem_mode, ctrl[2:0]}
  // ctrl = {mem_read, mem_write, reg_write}
  localparam int c_exmem_ctrl_lsb  = 0;
  localparam int c_exmem_mmode_lsb = c_exmem_ctrl_lsb + 3;
  localparam int c_exmem_rd_lsb    = c_exmem_mmode_lsb + MEM_MODE_WIDTH;
  localparam int c_exmem_st_lsb    = c_exmem_rd_lsb + RADDR_WIDTH;
  localparam int c_exmem_alu_lsb   = c_exmem_st_lsb + DATA_WIDTH;
  localparam int c_exmem_w         = c_exmem_alu_lsb + DATA_WIDTH;

  // MEM/WB payload: {wb_val, rd, reg_write}
  localparam int c_memwb_ctrl_lsb = 0;
  localparam int c_memwb_rd_lsb   = c_memwb_ctrl_lsb + 1;
  localparam int c_memwb_val_lsb  = c_memwb_rd_lsb + RADDR_WIDTH;
  localparam int c_memwb_w        = c_memwb_val_lsb + DATA_WIDTH;

  // IF/ID bubble carries a canonical addi x0,x0,0; later stages only need
  // every write/branch enable cleared, which all-zero guarantees.
  localparam logic [DATA_WIDTH-1:0] c_instr_nop = 32'h0000_0013;
  localparam logic [c_ifid_w-1:0]   c_ifid_nop  = {{PC_WIDTH{1'b0}}, c_instr_nop};
  localparam logic [c_idex_w-1:0]   c_idex_nop  = '0;
  localparam logic [c_exmem_w-1:0]  c_exmem_nop = '0;
  localparam logic [c_memwb_w-1:0]  c_memwb_nop = '0;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Valid/ready pipeline stage register with optional 2-entry skid
//            buffer, synchronous flush and saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
  parameter int                SKID    = 1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam logic             c_skid_en  = (SKID != 0);
  localparam logic [CNT_W-1:0] c_cnt_one  = 1;

  stage_state_e      r_state;
  stage_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_stall;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_stall    = out_valid & ~out_ready;
  assign stall_cnt  = r_stall_cnt;

  generate
    if (SKID != 0) begin : g_skid
      // in_ready depends on registered state only, breaking the ready chain.
      assign in_ready = (r_state != ST_FULL);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skid <= RST_VAL;
        end else begin
          r_skid <= w_skid_nxt;
        end
      end
    end else begin : g_no_skid
      assign in_ready = ~out_valid | out_ready;
      assign r_skid   = RST_VAL;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_nxt  = in_data;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = in_data;
        end else if (w_in_fire && c_skid_en) begin
          w_skid_nxt  = in_data;
          w_state_nxt = ST_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_main_nxt  = r_skid;
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush overrides everything, including a payload accepted this cycle.
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RST_VAL;
      w_skid_nxt  = RST_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

endmodule

`default_nettype wire
